// File: rtl/loader_pkg.sv
// Shared definitions for the cartridge/BIOS image loader: FSM encoding and
// default widths used by cart_loader and its stream FIFO.
package loader_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ADDR_W_DEF     = 22;
    localparam int LEN_W_DEF      = 20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous byte FIFO buffering the incoming image stream.
// Registered read/write pointers plus an occupancy counter; flush empties it.
module loader_fifo
    import loader_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == {CW{1'b0}});
    assign dout      = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cart_loader.sv
// Streams a cartridge/BIOS image into SRAM through the memory controller,
// one single-cycle write per byte; passes console reads through when idle.
module cart_loader
    import loader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              loading,
    output logic              done,
    output logic [LEN_W-1:0]  bytes_written,
    input  logic              cpu_read_a,
    input  logic              cpu_read_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              mc_read_a,
    output logic              mc_read_b,
    output logic              mc_write,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_din,
    input  logic              mc_busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remain;
    logic [LEN_W-1:0]  r_bytes_written;
    logic              w_start;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_head;

    assign w_start  = (r_state == ST_IDLE) & start;
    assign loading  = (r_state == ST_FETCH) | (r_state == ST_ISSUE) | (r_state == ST_WAIT);
    assign done     = (r_state == ST_FINISH);
    assign in_ready = loading & ~w_full;
    assign w_push   = in_valid & in_ready;
    // A write completes on the first non-busy cycle after the controller accepted it.
    assign w_pop    = (r_state == ST_WAIT) & ~mc_busy;
    assign mc_write = (r_state == ST_ISSUE) & ~mc_busy;
    assign mc_din   = w_head;
    assign bytes_written = r_bytes_written;

    loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (w_start),
        .push    (w_push),
        .pop     (w_pop),
        .din     (in_data),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (length == {LEN_W{1'b0}}) ? ST_FINISH : ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!w_empty) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (!mc_busy) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (!mc_busy) begin
                    w_next_state = (r_remain == LEN_ONE) ? ST_FINISH : ST_FETCH;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Load address, remaining count and progress counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= {ADDR_W{1'b0}};
            r_remain        <= {LEN_W{1'b0}};
            r_bytes_written <= {LEN_W{1'b0}};
        end else if (w_start) begin
            r_addr          <= base_addr;
            r_remain        <= length;
            r_bytes_written <= {LEN_W{1'b0}};
        end else if (w_pop) begin
            r_addr          <= r_addr + ADDR_W'(1'b1);
            r_remain        <= r_remain - LEN_ONE;
            r_bytes_written <= r_bytes_written + LEN_ONE;
        end
    end

    // Console pass-through only while idle; the loader owns the bus otherwise.
    always_comb begin
        mc_read_a = 1'b0;
        mc_read_b = 1'b0;
        mc_addr   = r_addr;
        if (r_state == ST_IDLE) begin
            mc_read_a = cpu_read_a;
            mc_read_b = cpu_read_b;
            mc_addr   = cpu_addr;
        end else begin
            mc_read_a = 1'b0;
            mc_read_b = 1'b0;
            mc_addr   = r_addr;
        end
    end

endmodule
